isp_boot_controller: RTL and testbench
======================================

# isp_boot_controller

Boot sequencer for `RISC_V_Core`. It holds the core in reset and streams a program image from an upstream source (UART/debug bridge) into program memory through the core's `isp_write`/`isp_address`/`isp_data` port. It then releases core reset and issues the one-cycle `start` pulse with the boot `prog_address`. It sits between the SoC boot source and the core, and replaces bench-driven `$readmemh` and `start` sequencing in hardware builds.

## Interface
- `DATA_WIDTH`, 32: ISP data word width.
- `ADDRESS_BITS`, 12: program-memory word-address width.
- `PROG_ADDRESS_BITS`, 20: width of core `prog_address`.
- `RESET_CYCLES`, 4: minimum cycles core reset is held before loading (≥1).
- `TIMEOUT_CYCLES`, 1024: max idle cycles between accepted words during load (≥2).

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low.
- `load_req`  in  1  request (re)boot; single-cycle pulse.
- `load_base`  in  ADDRESS_BITS  first word address; latched on accepted `load_req`.
- `load_count`  in  ADDRESS_BITS+1  words to load (0 = boot existing image); latched.
- `boot_address`  in  PROG_ADDRESS_BITS  core start PC; latched.
- `in_data`  in  DATA_WIDTH  image word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  controller accepts word this cycle.
- `isp_write`  out  1  program-memory write strobe.
- `isp_address`  out  ADDRESS_BITS  write address.
- `isp_data`  out  DATA_WIDTH  write data.
- `core_reset`  out  1  active-high reset to core.
- `start`  out  1  one-cycle start pulse to core.
- `prog_address`  out  PROG_ADDRESS_BITS  start PC to core.
- `busy`  out  1  boot sequence in progress.
- `done`  out  1  core running from last boot.
- `error`  out  1  load timed out.

## Operation
- States: IDLE, HOLD, LOAD, FLUSH, START, RUN, ERROR.
- IDLE: `core_reset`=1. Accepted `load_req` latches base/count/boot_address → HOLD.
- HOLD: `core_reset`=1, `busy`=1. Counts RESET_CYCLES cycles, then → LOAD, or → FLUSH if count=0.
- LOAD: `in_ready`=1. Each `in_valid && in_ready` handshake stores the word and increments the index. The handshake that accepts word `count-1` → FLUSH, and `in_ready` drops the next cycle.
- Watchdog in LOAD: cleared on each handshake and on LOAD entry. Reaching TIMEOUT_CYCLES with no handshake → ERROR.
- FLUSH: one cycle, `core_reset`=1, last ISP write completes → START.
- START: `core_reset`=0, `start`=1, `prog_address`=latched boot_address → RUN.
- RUN: `core_reset`=0, `done`=1, `busy`=0. `load_req` → HOLD, which re-asserts `core_reset` the next cycle and clears `done`.
- ERROR: `core_reset`=1, `error`=1 (sticky). `load_req` → HOLD and clears `error`.
- `load_req` in HOLD/LOAD/FLUSH/START is ignored.
- Address arithmetic: `isp_address` = (base + index) mod 2^ADDRESS_BITS, wrapping silently. Index width is ADDRESS_BITS+1; a `load_count` above 2^ADDRESS_BITS overwrites wrapped addresses (not an error).

## Timing
- All outputs are registered, except `in_ready`, which is decoded from the registered state.
- Reset values: state=IDLE, `core_reset`=1, `in_ready`=0, `isp_write`=0, `isp_address`=0, `isp_data`=0, `start`=0, `prog_address`=0, `busy`=0, `done`=0, `error`=0, counters=0.
- Accepting `load_req` at cycle t gives HOLD for cycles t+1..t+RESET_CYCLES and LOAD from t+RESET_CYCLES+1.
- Write latency: a handshake at cycle a gives `isp_write`=1 with that address/data at cycle a+1 (exactly one cycle per word). Back-to-back handshakes give back-to-back writes.
- Last handshake at a: FLUSH at a+1 (last write visible), START at a+2 (`core_reset`=0, `start`=1), RUN at a+3 (`start`=0, `done`=1).
- `load_count`=0: FLUSH follows HOLD directly, with no ISP writes.
- `prog_address` holds its value after START until the next START.
- Reset asserted mid-sequence: next cycle all reset values apply. The partially written image is left in memory and the core stays in reset.

## Structure
- Package `isp_boot_pkg`: state enum (7 encodings), default widths, state-name function for debug display.
- Sub-module `isp_boot_watchdog` (counter with clear/enable and `expired` output, parameter TIMEOUT_CYCLES).
- Top-level instantiation drives `core0` ISP/start/prog_address ports. The core `reset` is `core_reset` OR'd with system reset.

## Test plan
- Reset: hold `reset`=0 for 3 cycles → every output equals its reset value, `core_reset`=1.
- Contiguous load: base 0x010, count 4, words 0xA0..0xA3, `in_valid` always high, boot_address 0x00000 → writes 0x010..0x013 on consecutive cycles, `start` high exactly one cycle 2 cycles after last handshake, `done`=1 thereafter.
- Gaps and zero count: `in_valid` toggling every other cycle → 4 writes with data in order and no duplicates. Count 0 → no writes, and `start` comes RESET_CYCLES+2 cycles after request.
- Wrap: base 0xFFE, count 4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Timeout: TIMEOUT_CYCLES=16, supply 2 of 4 words then stop → `error`=1 exactly 16 cycles after 2nd handshake, `core_reset` stays 1, no `start`. New `load_req` → clean reload and boot.
- Rules: `load_req` during LOAD is ignored, with no change in index or latched values. `load_req` in RUN re-asserts `core_reset` in 1 cycle. `reset` low mid-LOAD → IDLE, `in_ready`=0 next cycle.

Source files
------------

// File: rtl/isp_boot_pkg.sv
// Shared types and default widths for the ISP boot sequencer.
// Also provides a state-name helper for debug display.
package isp_boot_pkg;

    localparam int DEF_DATA_WIDTH        = 32;
    localparam int DEF_ADDRESS_BITS      = 12;
    localparam int DEF_PROG_ADDRESS_BITS = 20;
    localparam int DEF_RESET_CYCLES      = 4;
    localparam int DEF_TIMEOUT_CYCLES    = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_LOAD,
        S_FLUSH,
        S_START,
        S_RUN,
        S_ERROR
    } boot_state_e;

    // Five ASCII characters, space padded.
    function automatic logic [39:0] state_name(input boot_state_e s);
        logic [39:0] name;
        case (s)
            S_IDLE:  name = "IDLE ";
            S_HOLD:  name = "HOLD ";
            S_LOAD:  name = "LOAD ";
            S_FLUSH: name = "FLUSH";
            S_START: name = "START";
            S_RUN:   name = "RUN  ";
            S_ERROR: name = "ERROR";
            default: name = "?????";
        endcase
        return name;
    endfunction

endpackage

// File: rtl/isp_boot_watchdog.sv
// Idle-cycle watchdog for the image load phase.
// Fires on the cycle that makes TIMEOUT_CYCLES since the last clear.
module isp_boot_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/isp_boot_controller.sv
// Boot sequencer: holds the core in reset, streams the program image
// into program memory over the ISP port, then starts the core.
module isp_boot_controller
    import isp_boot_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int ADDRESS_BITS      = DEF_ADDRESS_BITS,
    parameter int PROG_ADDRESS_BITS = DEF_PROG_ADDRESS_BITS,
    parameter int RESET_CYCLES      = DEF_RESET_CYCLES,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         load_req,
    input  logic [ADDRESS_BITS-1:0]      load_base,
    input  logic [ADDRESS_BITS:0]        load_count,
    input  logic [PROG_ADDRESS_BITS-1:0] boot_address,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         isp_write,
    output logic [ADDRESS_BITS-1:0]      isp_address,
    output logic [DATA_WIDTH-1:0]        isp_data,
    output logic                         core_reset,
    output logic                         start,
    output logic [PROG_ADDRESS_BITS-1:0] prog_address,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam int IW = ADDRESS_BITS + 1;

    boot_state_e state;
    boot_state_e state_n;

    logic [HW-1:0]                hold_cnt;
    logic [IW-1:0]                index;
    logic [IW-1:0]                count_q;
    logic [ADDRESS_BITS-1:0]      base_q;
    logic [PROG_ADDRESS_BITS-1:0] boot_q;

    logic accept;
    logic req_ok;
    logic last_word;
    logic wd_clear;
    logic wd_expired;

    assign in_ready  = (state == S_LOAD);
    assign accept    = in_valid && in_ready;
    assign req_ok    = load_req && ((state == S_IDLE) ||
                                    (state == S_RUN)  ||
                                    (state == S_ERROR));
    assign last_word = (index == (count_q - 1'b1));
    assign wd_clear  = !in_ready || accept;

    isp_boot_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (in_ready),
        .expired(wd_expired)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (req_ok) state_n = S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_n = (count_q == '0) ? S_FLUSH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept && last_word) begin
                    state_n = S_FLUSH;
                end else if (wd_expired) begin
                    state_n = S_ERROR;
                end
            end
            S_FLUSH: state_n = S_START;
            S_START: state_n = S_RUN;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_IDLE;
            hold_cnt     <= '0;
            index        <= '0;
            count_q      <= '0;
            base_q       <= '0;
            boot_q       <= '0;
            isp_write    <= 1'b0;
            isp_address  <= '0;
            isp_data     <= '0;
            core_reset   <= 1'b1;
            start        <= 1'b0;
            prog_address <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= (state == S_HOLD) ? hold_cnt + 1'b1 : '0;

            if (req_ok) begin
                base_q  <= load_base;
                count_q <= load_count;
                boot_q  <= boot_address;
                index   <= '0;
            end else if (accept) begin
                index <= index + 1'b1;
            end

            isp_write <= accept;
            if (accept) begin
                isp_address <= base_q + index[ADDRESS_BITS-1:0];
                isp_data    <= in_data;
            end

            core_reset <= !((state_n == S_START) || (state_n == S_RUN));
            busy       <= (state_n == S_HOLD)  || (state_n == S_LOAD) ||
                          (state_n == S_FLUSH) || (state_n == S_START);
            done       <= (state_n == S_RUN);
            error      <= (state_n == S_ERROR);
            start      <= (state_n == S_START);
            if (state_n == S_START) prog_address <= boot_q;
        end
    end

endmodule

// File: tb/tb_isp_boot_controller.sv
// Directed and randomized boot sequences checked against a cycle-level
// model of the boot protocol held in the bench.
module tb_isp_boot_controller;

    localparam int DW  = 32;
    localparam int AB  = 12;
    localparam int PB  = 20;
    localparam int RC  = 4;
    localparam int TMO = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          load_req = 1'b0;
    logic [AB-1:0] load_base = '0;
    logic [AB:0]   load_count = '0;
    logic [PB-1:0] boot_address = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          isp_write;
    logic [AB-1:0] isp_address;
    logic [DW-1:0] isp_data;
    logic          core_reset;
    logic          start;
    logic [PB-1:0] prog_address;
    logic          busy;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;

    isp_boot_controller #(
        .DATA_WIDTH       (DW),
        .ADDRESS_BITS     (AB),
        .PROG_ADDRESS_BITS(PB),
        .RESET_CYCLES     (RC),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .load_req    (load_req),
        .load_base   (load_base),
        .load_count  (load_count),
        .boot_address(boot_address),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .isp_write   (isp_write),
        .isp_address (isp_address),
        .isp_data    (isp_data),
        .core_reset  (core_reset),
        .start       (start),
        .prog_address(prog_address),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 always valid, 1 every other cycle, 2 random.
    // stop_after < cnt models a stalled source (timeout expected).
    task automatic boot(input logic [AB-1:0] base, input int cnt,
                        input logic [PB-1:0] pc, input int mode,
                        input int stop_after, input bit poke,
                        input bit fixed);
        logic [DW-1:0] words[$];
        logic [AB-1:0] paddr;
        logic [DW-1:0] pdata;
        logic          pend;
        logic          v;
        bit            timed_out;
        int            acc;
        int            cyc;
        int            idle;
        for (int i = 0; i < cnt; i++) begin
            words.push_back(fixed ? DW'(32'hA0 + i) : DW'($urandom));
        end
        in_valid     = 1'b0;
        load_req     = 1'b1;
        load_base    = base;
        load_count   = (AB+1)'(cnt);
        boot_address = pc;
        tick();
        load_req = 1'b0;
        for (int k = 1; k <= RC; k++) begin
            chk1("hold_core_reset", core_reset, 1'b1);
            chk1("hold_busy", busy, 1'b1);
            chk1("hold_ready", in_ready, 1'b0);
            chk1("hold_done", done, 1'b0);
            chk1("hold_error", error, 1'b0);
            chk1("hold_start", start, 1'b0);
            tick();
        end
        acc = 0; cyc = 0; idle = 1; pend = 1'b0;
        paddr = '0; pdata = '0; timed_out = 1'b0;
        while (acc < cnt && cyc < 300) begin
            if (idle >= TMO) begin
                chk1("tmo_error", error, 1'b1);
                chk1("tmo_core_reset", core_reset, 1'b1);
                chk1("tmo_ready", in_ready, 1'b0);
                chk1("tmo_start", start, 1'b0);
                chk1("tmo_write", isp_write, 1'b0);
                timed_out = 1'b1;
                break;
            end
            chk1("load_ready", in_ready, 1'b1);
            chk1("load_error", error, 1'b0);
            chk1("load_core_reset", core_reset, 1'b1);
            chk1("load_start", start, 1'b0);
            chk1("load_write", isp_write, pend);
            if (pend) begin
                chkv("load_addr", 64'(isp_address), 64'(paddr));
                chkv("load_data", 64'(isp_data), 64'(pdata));
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = (idle >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            if (acc >= stop_after) v = 1'b0;
            if (poke && cyc == 1) begin
                load_req     = 1'b1;
                load_base    = ~base;
                load_count   = (AB+1)'($urandom_range(1, 20));
                boot_address = ~pc;
            end
            in_valid = v;
            in_data  = v ? words[acc] : DW'($urandom);
            pend     = v;
            if (v) begin
                paddr = base + acc[AB-1:0];
                pdata = words[acc];
                acc++;
                idle = 0;
            end
            tick();
            load_req = 1'b0;
            cyc++;
            idle++;
        end
        in_valid = 1'b0;
        if (timed_out) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                chk1("err_sticky", error, 1'b1);
                chk1("err_start", start, 1'b0);
                chk1("err_core_reset", core_reset, 1'b1);
            end
            return;
        end
        if (acc < cnt) chkv("load_budget", 64'(acc), 64'(cnt));
        chk1("flush_write", isp_write, pend);
        if (pend) begin
            chkv("flush_addr", 64'(isp_address), 64'(paddr));
            chkv("flush_data", 64'(isp_data), 64'(pdata));
        end
        chk1("flush_ready", in_ready, 1'b0);
        chk1("flush_core_reset", core_reset, 1'b1);
        chk1("flush_start", start, 1'b0);
        tick();
        chk1("start_pulse", start, 1'b1);
        chk1("start_core_reset", core_reset, 1'b0);
        chk1("start_write", isp_write, 1'b0);
        chk1("start_done", done, 1'b0);
        chkv("start_pc", 64'(prog_address), 64'(pc));
        tick();
        chk1("run_start", start, 1'b0);
        chk1("run_done", done, 1'b1);
        chk1("run_busy", busy, 1'b0);
        chk1("run_core_reset", core_reset, 1'b0);
        chk1("run_error", error, 1'b0);
        chkv("run_pc", 64'(prog_address), 64'(pc));
        tick();
        chk1("run_stay", done, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) tick();
        chk1("rst_core_reset", core_reset, 1'b1);
        chk1("rst_ready", in_ready, 1'b0);
        chk1("rst_write", isp_write, 1'b0);
        chkv("rst_addr", 64'(isp_address), 64'd0);
        chkv("rst_data", 64'(isp_data), 64'd0);
        chk1("rst_start", start, 1'b0);
        chkv("rst_pc", 64'(prog_address), 64'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0);
        reset = 1'b1;
        tick();
        chk1("idle_core_reset", core_reset, 1'b1);

        boot(12'h010, 4, 20'h00000, 0, 4, 1'b0, 1'b1);
        boot(12'h123, 4, 20'h00400, 1, 4, 1'b0, 1'b0);
        boot(12'h055, 0, 20'h12345, 0, 0, 1'b0, 1'b0);
        boot(12'hFFE, 4, 20'h0ABCD, 2, 4, 1'b0, 1'b0);
        boot(12'h200, 4, 20'h00777, 0, 2, 1'b0, 1'b0);
        boot(12'h300, 3, 20'h00888, 2, 3, 1'b0, 1'b0);
        boot(12'h400, 5, 20'h00999, 0, 5, 1'b1, 1'b0);

        // Reset pulled low while words are streaming.
        load_req   = 1'b1;
        load_base  = 12'h500;
        load_count = 13'd6;
        tick();
        load_req = 1'b0;
        repeat (RC) tick();
        chk1("mid_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'hDEAD0001;
        repeat (2) tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk1("mid_rst_ready", in_ready, 1'b0);
        chk1("mid_rst_write", isp_write, 1'b0);
        chk1("mid_rst_core_reset", core_reset, 1'b1);
        chk1("mid_rst_busy", busy, 1'b0);
        chkv("mid_rst_addr", 64'(isp_address), 64'd0);
        chkv("mid_rst_pc", 64'(prog_address), 64'd0);
        reset = 1'b1;
        repeat (3) tick();
        chk1("mid_idle_ready", in_ready, 1'b0);
        chk1("mid_idle_core_reset", core_reset, 1'b1);

        for (int n = 0; n < 6; n++) begin
            int c;
            c = $urandom_range(1, 8);
            boot(AB'($urandom_range(0, 4095)), c,
                 PB'($urandom), 2, c, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
